time_set_controller: RTL

TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

---
 rtl/time_set_pkg.sv | 31 +++
 rtl/field_stepper.sv | 25 ++
 rtl/time_set_controller.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/time_set_pkg.sv
// Shared definitions for the time-set controller.
//   state_e      : controller FSM states
//   field_e      : field_sel output encoding (0 none, 1 hour, 2 min, 3 sec)
//   MAX_HOUR     : largest legal hour value
//   MAX_SEC_MIN  : largest legal minute/second value
//   clamp_field  : maps an out-of-range live value to 0 when it is loaded for editing
package time_set_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StEditHour,
        StEditMin,
        StEditSec,
        StCommit
    } state_e;

    typedef enum logic [1:0] {
        FieldNone = 2'd0,
        FieldHour = 2'd1,
        FieldMin  = 2'd2,
        FieldSec  = 2'd3
    } field_e;

    localparam logic [7:0] MAX_HOUR    = 8'd23;
    localparam logic [7:0] MAX_SEC_MIN = 8'd59;

    function automatic logic [7:0] clamp_field(input logic [7:0] value, input logic [7:0] max);
        return (value > max) ? 8'd0 : value;
    endfunction

endpackage

// File: rtl/field_stepper.sv
// Combinational wrap-around stepper for one time field.
//   value  : current field value (0..max)
//   max    : largest legal value for this field
//   inc    : step up by one, max wraps to 0
//   dec    : step down by one, 0 wraps to max
//   result : stepped value; inc and dec together leave the value unchanged
module field_stepper (
    input  logic [7:0] value,
    input  logic [7:0] max,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] result
);

    always_comb begin
        result = value;
        if (inc && !dec) begin
            result = (value >= max) ? 8'd0 : value + 8'd1;
        end else if (dec && !inc) begin
            // An out-of-range value also lands on max so the result stays legal.
            result = ((value == 8'd0) || (value > max)) ? max : value - 8'd1;
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// Button-driven editor for a 24-hour clock.
// A btn_edit press copies the live time into edit registers; btn_next cycles the
// selected field (hour -> min -> sec), btn_inc/btn_dec step it with wrap-around, and a
// second btn_edit press writes the result back with a one-cycle set_time strobe.
// An edit left untouched for TIMEOUT_CYCLES is abandoned without a strobe.
//
// Optional feature: define TIME_SET_AUTOREPEAT_EN to auto-repeat a held inc/dec button
// (first repeat HOLD_CYCLES after the press, then every REPEAT_CYCLES).
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   btn_edit/next/inc/dec         debounced button levels
//   cur_hour/min/sec              live time from the clock core
//   set_time                      one-cycle write strobe to the clock core
//   out_hour/min/sec              edit registers (valid whenever set_time=1)
//   editing                       high while a field is being edited
//   field_sel                     0 none, 1 hour, 2 min, 3 sec
module time_set_controller
    import time_set_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned REPEAT_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_edit,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [7:0] cur_sec,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_hour,
    output logic       set_time,
    output logic [7:0] out_sec,
    output logic [7:0] out_min,
    output logic [7:0] out_hour,
    output logic       editing,
    output logic [1:0] field_sel
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

    state_e            state_q, state_d;
    logic [7:0]        hour_q, hour_d;
    logic [7:0]        min_q, min_d;
    logic [7:0]        sec_q, sec_d;
    logic [TimerW-1:0] timer_q, timer_d;

    // Button history for rising-edge detection.
    logic edit_q, next_q, inc_q, dec_q;
    logic edit_edge, next_edge, inc_edge, dec_edge, any_edge;

    assign edit_edge = btn_edit & ~edit_q;
    assign next_edge = btn_next & ~next_q;
    assign inc_edge  = btn_inc  & ~inc_q;
    assign dec_edge  = btn_dec  & ~dec_q;
    assign any_edge  = edit_edge | next_edge | inc_edge | dec_edge;

    logic in_edit;
    assign in_edit = (state_q == StEditHour) || (state_q == StEditMin) ||
                     (state_q == StEditSec);

    // Auto-repeat step request for the held inc/dec button.
    logic rep_step;

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned RepW  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    logic [HoldW-1:0] hold_q, hold_d;
    logic [RepW-1:0]  rep_q, rep_d;
    logic             rep_active;

    // Only one of inc/dec held counts; holding both never repeats.
    assign rep_active = in_edit && (btn_inc ^ btn_dec);

    always_comb begin
        hold_d   = hold_q;
        rep_d    = '0;
        rep_step = 1'b0;
        // hold_q is cycles since the last press, saturating at HOLD_CYCLES; zero means
        // no press is being tracked (a level held from before does not repeat).
        if (!rep_active) begin
            hold_d = '0;
        end else if (inc_edge || dec_edge) begin
            hold_d = HoldW'(1);
        end else if ((hold_q != '0) && (hold_q != HoldW'(HOLD_CYCLES))) begin
            hold_d = hold_q + HoldW'(1);
        end
        if (rep_active && !(inc_edge || dec_edge) && (hold_q == HoldW'(HOLD_CYCLES))) begin
            rep_step = (rep_q == '0);
            rep_d    = (rep_q == RepW'(REPEAT_CYCLES - 1)) ? '0 : rep_q + RepW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            rep_q  <= '0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end
`else
    assign rep_step = 1'b0;
`endif

    // Selected-field stepper.
    logic [7:0] sel_value, sel_max, step_result;
    logic       step_inc, step_dec;

    assign step_inc = inc_edge | (rep_step & btn_inc);
    assign step_dec = dec_edge | (rep_step & btn_dec);

    always_comb begin
        sel_value = hour_q;
        sel_max   = MAX_HOUR;
        unique case (state_q)
            StEditMin: begin
                sel_value = min_q;
                sel_max   = MAX_SEC_MIN;
            end
            StEditSec: begin
                sel_value = sec_q;
                sel_max   = MAX_SEC_MIN;
            end
            default: begin
                sel_value = hour_q;
                sel_max   = MAX_HOUR;
            end
        endcase
    end

    field_stepper u_field_stepper (
        .value  (sel_value),
        .max    (sel_max),
        .inc    (step_inc),
        .dec    (step_dec),
        .result (step_result)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        timer_d = timer_q;

        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (edit_edge) begin
                    state_d = StEditHour;
                    hour_d  = clamp_field(cur_hour, MAX_HOUR);
                    min_d   = clamp_field(cur_min, MAX_SEC_MIN);
                    sec_d   = clamp_field(cur_sec, MAX_SEC_MIN);
                end
            end

            StEditHour, StEditMin, StEditSec: begin
                if (edit_edge) begin
                    state_d = StCommit;
                end else if (next_edge) begin
                    unique case (state_q)
                        StEditHour: state_d = StEditMin;
                        StEditMin:  state_d = StEditSec;
                        default:    state_d = StEditHour;
                    endcase
                end else begin
                    // step_result equals the current value when no step is requested.
                    unique case (state_q)
                        StEditHour: hour_d = step_result;
                        StEditMin:  min_d  = step_result;
                        default:    sec_d  = step_result;
                    endcase
                end

                if (any_edge || rep_step) begin
                    timer_d = '0;
                end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end

            StCommit: begin
                state_d = StIdle;
                timer_d = '0;
            end

            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            timer_q <= '0;
            edit_q  <= 1'b0;
            next_q  <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            timer_q <= timer_d;
            edit_q  <= btn_edit;
            next_q  <= btn_next;
            inc_q   <= btn_inc;
            dec_q   <= btn_dec;
        end
    end

    // Outputs.
    always_comb begin
        field_sel = FieldNone;
        unique case (state_q)
            StEditHour: field_sel = FieldHour;
            StEditMin:  field_sel = FieldMin;
            StEditSec:  field_sel = FieldSec;
            default:    field_sel = FieldNone;
        endcase
    end

    assign editing  = in_edit;
    assign set_time = (state_q == StCommit);
    assign out_hour = hour_q;
    assign out_min  = min_q;
    assign out_sec  = sec_q;

endmodule
